// File: rtl/chrominance_downsampling.sv
// chrominance_downsampling: 4:2:0 chroma downsampling of an 8x8 Cb/Cr block pair
//
// Each 2x2 quad of both components is averaged and the average is replicated
// into all four positions of the quad. One row pair (four quads per component)
// is processed per clock, so the result is ready four clocks after capture.
//
// Ports:
//   Clock    in   1    rising-edge system clock
//   reset    in   1    asynchronous active-low reset
//   Enable0  in   1    start request (level-sensitive), must drop before a rerun
//   Cb, Cr   in   512  8x8 blocks of unsigned 8-bit samples, (i,j) at [511-8*(8i+j) -: 8]
//   Cb_d     out  512  downsampled Cb block, same layout, registered
//   Cr_d     out  512  downsampled Cr block, same layout, registered
//   enable1  out  1    result valid, held while Enable0 stays high
//
// Configuration macro:
//   CHROMA_ROUND_EN  defined: quad = (sum+2)>>2 (round half up)
//                    undefined: quad = sum>>2 (truncate)
module chrominance_downsampling (
    input  logic         Clock,
    input  logic         reset,
    input  logic         Enable0,
    input  logic [511:0] Cb,
    input  logic [511:0] Cr,
    output logic [511:0] Cb_d,
    output logic [511:0] Cr_d,
    output logic         enable1
);
    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t       r_state;
    logic [1:0]   r_k;
    logic [511:0] r_cb, r_cr;
    logic [511:0] r_cb_w, r_cr_w;
    logic [511:0] r_cb_d, r_cr_d;
    logic         r_en1;
    logic [511:0] w_cb_next, w_cr_next;

    function automatic int pos(int r, int c);
        return 511 - 8 * (8 * r + c);
    endfunction

    // Sum fits in 10 bits even with the rounding offset (4*255+2 = 1022).
    function automatic logic [7:0] avg4(input logic [7:0] a, b, c, d);
        logic [9:0] s;
        s = 10'(a) + 10'(b) + 10'(c) + 10'(d);
`ifdef CHROMA_ROUND_EN
        s = s + 10'd2;
`endif
        return s[9:2];
    endfunction

    // Every quad is averaged in parallel; only the row pair selected by r_k is
    // merged into the working image, the rest passes through unchanged.
    genvar p, q, d;
    generate
        for (p = 0; p < 4; p++) begin : g_row
            for (q = 0; q < 4; q++) begin : g_col
                logic [7:0] w_cb_avg, w_cr_avg;
                assign w_cb_avg = avg4(r_cb[pos(2*p, 2*q) -: 8], r_cb[pos(2*p, 2*q+1) -: 8],
                                       r_cb[pos(2*p+1, 2*q) -: 8], r_cb[pos(2*p+1, 2*q+1) -: 8]);
                assign w_cr_avg = avg4(r_cr[pos(2*p, 2*q) -: 8], r_cr[pos(2*p, 2*q+1) -: 8],
                                       r_cr[pos(2*p+1, 2*q) -: 8], r_cr[pos(2*p+1, 2*q+1) -: 8]);
                for (d = 0; d < 4; d++) begin : g_pix
                    localparam int P = pos(2*p + d/2, 2*q + d%2);
                    assign w_cb_next[P -: 8] = (r_k == 2'(p)) ? w_cb_avg : r_cb_w[P -: 8];
                    assign w_cr_next[P -: 8] = (r_k == 2'(p)) ? w_cr_avg : r_cr_w[P -: 8];
                end
            end
        end
    endgenerate

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_k     <= 2'd0;
            r_cb    <= '0;
            r_cr    <= '0;
            r_cb_w  <= '0;
            r_cr_w  <= '0;
            r_cb_d  <= '0;
            r_cr_d  <= '0;
            r_en1   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Enable0) begin
                        r_cb    <= Cb;
                        r_cr    <= Cr;
                        r_k     <= 2'd0;
                        r_state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    r_cb_w <= w_cb_next;
                    r_cr_w <= w_cr_next;
                    r_k    <= r_k + 2'd1;
                    // Last row pair: publish the complete image in one edge.
                    if (r_k == 2'd3) begin
                        r_cb_d  <= w_cb_next;
                        r_cr_d  <= w_cr_next;
                        r_en1   <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (!Enable0) begin
                        r_en1   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Cb_d    = r_cb_d;
    assign Cr_d    = r_cr_d;
    assign enable1 = r_en1;
endmodule

// File: tb/tb_chrominance_downsampling.sv
// tb_chrominance_downsampling: randomized self-checking bench against a quad-average model
module tb_chrominance_downsampling;
    logic         Clock = 1'b0;
    logic         reset = 1'b0;
    logic         Enable0 = 1'b0;
    logic [511:0] Cb = '0, Cr = '0;
    logic [511:0] Cb_d, Cr_d;
    logic         enable1;
    int           n_checks = 0;
    int           n_fails = 0;

    chrominance_downsampling dut (
        .Clock(Clock), .reset(reset), .Enable0(Enable0), .Cb(Cb), .Cr(Cr),
        .Cb_d(Cb_d), .Cr_d(Cr_d), .enable1(enable1)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] el(input logic [511:0] b, input int i, input int j);
        return b[511 - 8 * (8 * i + j) -: 8];
    endfunction

    function automatic logic [511:0] put(input logic [511:0] b, input int i, input int j, input logic [7:0] v);
        b[511 - 8 * (8 * i + j) -: 8] = v;
        return b;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Each output pixel is the average of the 2x2 quad it belongs to.
    function automatic logic [511:0] model(input logic [511:0] b);
        logic [511:0] o;
        int s, i0, j0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                i0 = i - i % 2;
                j0 = j - j % 2;
                s = el(b, i0, j0) + el(b, i0, j0 + 1) + el(b, i0 + 1, j0) + el(b, i0 + 1, j0 + 1);
`ifdef CHROMA_ROUND_EN
                s = (s + 2) / 4;
`else
                s = s / 4;
`endif
                o = put(o, i, j, 8'(s));
            end
        return o;
    endfunction

    task automatic run(input logic [511:0] cb, input logic [511:0] cr);
        int n;
        @(negedge Clock);
        Cb = cb;
        Cr = cr;
        Enable0 = 1'b1;
        @(posedge Clock);
        #1;
        Cb = rnd512();
        Cr = rnd512();
        Enable0 = 1'($urandom);
        n = 0;
        while (!enable1 && n < 8) begin
            @(posedge Clock);
            #1;
            n++;
        end
        Enable0 = 1'b1;
        check("latency", 512'(n), 512'(4));
        check("cb_d", Cb_d, model(cb));
        check("cr_d", Cr_d, model(cr));
        repeat (3) begin
            @(posedge Clock);
            #1;
        end
        check("hold_en1", 512'(enable1), 512'(1));
        check("hold_cb_d", Cb_d, model(cb));
        Enable0 = 1'b0;
        @(posedge Clock);
        #1;
        check("drop_en1", 512'(enable1), 512'(0));
        check("drop_cr_d", Cr_d, model(cr));
        @(posedge Clock);
        #1;
    endtask

    initial begin
        logic [511:0] cb, cr;
        repeat (2) @(posedge Clock);
        #1;
        check("rst_en1", 512'(enable1), 512'(0));
        check("rst_cb_d", Cb_d, '0);
        check("rst_cr_d", Cr_d, '0);
        @(negedge Clock);
        reset = 1'b1;

        cb = rnd512();
        cr = rnd512();
        cb = put(cb, 0, 0, 8'd111); cb = put(cb, 0, 1, 8'd111);
        cb = put(cb, 1, 0, 8'd110); cb = put(cb, 1, 1, 8'd110);
        cb = put(cb, 6, 0, 8'd104); cb = put(cb, 6, 1, 8'd104);
        cb = put(cb, 7, 0, 8'd90);  cb = put(cb, 7, 1, 8'd104);
        cr = put(cr, 0, 0, 8'd166); cr = put(cr, 0, 1, 8'd167);
        cr = put(cr, 1, 0, 8'd167); cr = put(cr, 1, 1, 8'd168);
        run(cb, cr);
        @(negedge Clock);
        Enable0 = 1'b1;
        Cb = cb;
        Cr = cr;
        repeat (5) @(posedge Clock);
        #1;
        Enable0 = 1'b1;
        // Quad sums: 442 -> 110.5, 402 -> 100.5, 668 -> 167.
`ifdef CHROMA_ROUND_EN
        check("quad_cb_00", 512'(el(Cb_d, 0, 0)), 512'(111));
        check("quad_cb_11", 512'(el(Cb_d, 1, 1)), 512'(111));
        check("quad_cb_70", 512'(el(Cb_d, 7, 0)), 512'(101));
`else
        check("quad_cb_00", 512'(el(Cb_d, 0, 0)), 512'(110));
        check("quad_cb_11", 512'(el(Cb_d, 1, 1)), 512'(110));
        check("quad_cb_70", 512'(el(Cb_d, 7, 0)), 512'(100));
`endif
        check("quad_cr_01", 512'(el(Cr_d, 0, 1)), 512'(167));
        check("quad_cr_10", 512'(el(Cr_d, 1, 0)), 512'(167));
        check("rerun_en1", 512'(enable1), 512'(1));
        @(negedge Clock);
        Enable0 = 1'b0;
        repeat (2) @(posedge Clock);
        #1;

        run({512{1'b1}}, {512{1'b1}});
        check("sat_cb", Cb_d, {512{1'b1}});

        run('0, rnd512());

        @(negedge Clock);
        Cb = rnd512();
        Cr = rnd512();
        Enable0 = 1'b1;
        @(posedge Clock);
        #1;
        Enable0 = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        reset = 1'b0;
        #1;
        check("async_en1", 512'(enable1), 512'(0));
        check("async_cb_d", Cb_d, '0);
        check("async_cr_d", Cr_d, '0);
        @(negedge Clock);
        reset = 1'b1;
        repeat (6) @(posedge Clock);
        #1;
        check("abort_en1", 512'(enable1), 512'(0));
        check("abort_cb_d", Cb_d, '0);

        repeat (6) run(rnd512(), rnd512());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
